key_code_gen: RTL
=================

KEY_CODE_GEN -- requirements
Module: key_code_gen

Interface
REQ-001 SHALL have parameter CNT_DEB_MAX, default 999_999, debounce count (20 ms at 50 MHz).
REQ-002 SHALL have parameter CNT_STEP_MAX, default 24_999_999, auto-step period minus 1 (0.5 s at 50 MHz).
REQ-003 SHALL have port sys_clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port sys_rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port key_up  input  1  raw button, active-low, asynchronous to sys_clk.
REQ-006 SHALL have port key_down  input  1  raw button, active-low, asynchronous.
REQ-007 SHALL have port key_mode  input  1  raw button, active-low, asynchronous.
REQ-008 SHALL have port out1  output  1  code bit 2 (MSB), feeds the 3-to-8 decoder's in1.
REQ-009 SHALL have port out2  output  1  code bit 1, feeds in2.
REQ-010 SHALL have port out3  output  1  code bit 0 (LSB), feeds in3.
REQ-011 SHALL have port mode_led  output  1  1 = auto mode, 0 = manual mode.

Function
REQ-012 SHALL pass each key through a 2-flop synchronizer; sync output = key delayed 2 clocks.
REQ-013 SHALL keep one debounce counter per key: sync key = 1 -> counter 0; sync key = 0 and counter < CNT_DEB_MAX -> +1; at CNT_DEB_MAX -> hold.
REQ-014 SHALL generate a one-clock press pulse per key when its counter = CNT_DEB_MAX-1 and its sync key = 0; exactly one pulse per hold, however long.
REQ-015 SHALL ignore glitches shorter than CNT_DEB_MAX clocks; any release restarts the count from 0.
REQ-016 SHALL hold a 3-bit code register; out1/out2/out3 = code[2]/code[1]/code[0], driven directly from flops.
REQ-017 SHALL toggle mode on a key_mode pulse, effective next clock edge.
REQ-018 Manual mode: key_up pulse -> code+1; key_down pulse -> code-1; updated next edge (1-clock latency from pulse).
REQ-019 SHALL wrap code modulo 8: 7 + 1 -> 0 and 0 - 1 -> 7.
REQ-020 Manual mode: key_up and key_down pulses in the same clock -> code unchanged.
REQ-021 Manual mode: step counter held at 0.
REQ-022 Auto mode: step counter counts 0..CNT_STEP_MAX; at CNT_STEP_MAX -> counter returns to 0 and code+1 (wrapping), so one step per CNT_STEP_MAX+1 clocks.
REQ-023 Auto mode: key_up/key_down pulses ignored.
REQ-024 SHALL, on entering auto mode, start the step counter from 0; first step exactly CNT_STEP_MAX+1 clocks after the toggle edge.
REQ-025 SHALL, on a key_mode pulse coincident with key_up/key_down or an auto step, toggle mode only; code unchanged that clock.
REQ-026 SHALL, on leaving auto mode, keep the current code and clear the step counter to 0.

Reset
REQ-027 SHALL, while sys_rst_n = 0, asynchronously force: code = 0 (out1..out3 = 0), mode_led = 0, all counters = 0, synchronizer flops = 1.
REQ-028 SHALL resume on the first rising edge after release; a key held low across reset SHALL need a full CNT_DEB_MAX count before its pulse.
REQ-029 SHALL, on reset mid-auto-step or mid-debounce, discard partial counts with no pulse or step.

Verification (bench params CNT_DEB_MAX=4, CNT_STEP_MAX=9)
REQ-030 key_up held low 20 clocks from reset -> one pulse, {out1,out2,out3} = 001; nothing further until release and re-press.
REQ-031 key_down low for 3 clocks, released, repeated 5 times -> code stays 000; then held 10 clocks -> code = 111 (wrap).
REQ-032 key_up and key_down pressed in exactly the same clock, code 011 -> code stays 011.
REQ-033 key_mode press -> mode_led = 1; code 000 steps at 10-clock intervals 001, 010 ... 111, 000; key_up presses ignored.
REQ-034 Auto mode, code 101, key_mode pulse on the step clock -> mode_led = 0, code stays 101, step counter 0.
REQ-035 sys_rst_n driven low mid-count, asynchronous to sys_clk, with code 110 -> outputs 000 and mode_led 0 immediately, before any clock edge.

Source files
------------

// File: rtl/key_code_gen.sv
// Three-button code generator: debounced up/down/mode keys drive a 3-bit code
// for a 3-to-8 decoder, either stepped by hand or advanced automatically.
module key_code_gen #(
  parameter int CNT_DEB_MAX  = 999_999,
  parameter int CNT_STEP_MAX = 24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_up,
  input  logic key_down,
  input  logic key_mode,
  output logic out1,
  output logic out2,
  output logic out3,
  output logic mode_led
);

  localparam int DEB_W  = $clog2(CNT_DEB_MAX + 1);
  localparam int STEP_W = $clog2(CNT_STEP_MAX + 1);
  localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(CNT_DEB_MAX);
  localparam logic [DEB_W-1:0]  DEB_HIT  = DEB_W'(CNT_DEB_MAX - 1);
  localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(CNT_STEP_MAX);

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Key lanes: bit 0 = up, bit 1 = down, bit 2 = mode.
  logic [2:0]       keys_s;
  logic [2:0]       meta_q;
  logic [2:0]       sync_q;
  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];
  logic [2:0]       pulse_s;

  mode_e             mode_q, mode_d;
  logic [2:0]        code_q, code_d;
  logic [STEP_W-1:0] step_q, step_d;

  assign keys_s = {key_mode, key_down, key_up};

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      meta_q <= 3'b111;
      sync_q <= 3'b111;
    end else begin
      meta_q <= keys_s;
      sync_q <= meta_q;
    end
  end

  // Counter saturates at DEB_MAX, so the DEB_HIT match fires once per hold.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      deb_cnt_d[k] = deb_cnt_q[k];
      pulse_s[k]   = 1'b0;
      if (sync_q[k]) begin
        deb_cnt_d[k] = {DEB_W{1'b0}};
      end else if (deb_cnt_q[k] < DEB_MAX) begin
        deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
      end else begin
        deb_cnt_d[k] = deb_cnt_q[k];
      end
      pulse_s[k] = ~sync_q[k] & (deb_cnt_q[k] == DEB_HIT);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        deb_cnt_q[k] <= {DEB_W{1'b0}};
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
      end
    end
  end

  // A mode toggle takes priority and freezes the code for that clock.
  always_comb begin
    mode_d = mode_q;
    code_d = code_q;
    step_d = step_q;
    if (pulse_s[2]) begin
      mode_d = (mode_q == MODE_AUTO) ? MODE_MANUAL : MODE_AUTO;
      step_d = {STEP_W{1'b0}};
    end else begin
      case (mode_q)
        MODE_AUTO: begin
          if (step_q == STEP_MAX) begin
            step_d = {STEP_W{1'b0}};
            code_d = code_q + 3'd1;
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
        MODE_MANUAL: begin
          step_d = {STEP_W{1'b0}};
          if (pulse_s[0] && !pulse_s[1]) begin
            code_d = code_q + 3'd1;
          end else if (pulse_s[1] && !pulse_s[0]) begin
            code_d = code_q - 3'd1;
          end else begin
            code_d = code_q;
          end
        end
        default: begin
          mode_d = MODE_MANUAL;
          step_d = {STEP_W{1'b0}};
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q <= MODE_MANUAL;
      code_q <= 3'd0;
      step_q <= {STEP_W{1'b0}};
    end else begin
      mode_q <= mode_d;
      code_q <= code_d;
      step_q <= step_d;
    end
  end

  assign out1     = code_q[2];
  assign out2     = code_q[1];
  assign out3     = code_q[0];
  assign mode_led = (mode_q == MODE_AUTO);

endmodule
